// File: rtl/branch_predict_resolve.sv
// Decode-stage branch resolution with a 2-bit saturating-counter branch history table.
// Prediction is looked up at fetch; conditional branches train the table when they resolve.
module branch_predict_resolve #(
  parameter int DW         = 32,
  parameter int BHT_IDX    = 6,
  parameter int PREDICT_EN = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_inst,
  input  logic [DW-1:0]    id_ra,
  input  logic [DW-1:0]    id_rb,
  input  logic             id_pred_taken,
  output logic             res_valid,
  output logic [1:0]       res_sel,
  output logic             res_mispredict,
  output logic             res_flush,
  output logic [CNT_W-1:0] perf_br_cnt,
  output logic [CNT_W-1:0] perf_mp_cnt
);

  localparam int ENTRIES = 1 << BHT_IDX;

  logic [BHT_IDX-1:0] if_idx;
  logic [BHT_IDX-1:0] id_idx;
  logic [1:0]         bht_q [ENTRIES];
  logic [1:0]         ctr_cur;
  logic [1:0]         ctr_next;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       fire;
  logic       is_cond;
  logic       taken;
  logic       ra_le_zero;
  logic       bht_upd;
  logic [1:0] sel_next;
  logic       mp_next;

  logic       res_valid_reg;
  logic [1:0] res_sel_reg;
  logic       res_mp_reg;
  logic       res_flush_reg;
  logic [CNT_W-1:0] perf_br_reg;
  logic [CNT_W-1:0] perf_mp_reg;

  logic unused_bits;
  assign unused_bits = ^{if_pc[31:BHT_IDX+2], if_pc[1:0], id_pc[31:BHT_IDX+2], id_pc[1:0], id_inst[25:6]};

  assign if_idx = if_pc[BHT_IDX+1:2];
  assign id_idx = id_pc[BHT_IDX+1:2];
  assign opcode = id_inst[31:26];
  assign funct  = id_inst[5:0];
  assign fire   = id_valid & ~id_stall;

  // Signed ra <= 0 is just "sign bit set or all zero", so no signed compare is needed.
  assign ra_le_zero = id_ra[DW-1] | (id_ra == '0);

  always_comb begin
    is_cond  = 1'b0;
    taken    = 1'b0;
    sel_next = 2'b00;
    case (opcode)
      6'b000100: begin is_cond = 1'b1; taken = (id_ra == id_rb); end
      6'b000101: begin is_cond = 1'b1; taken = (id_ra != id_rb); end
      6'b000110: begin is_cond = 1'b1; taken = ra_le_zero;        end
      6'b000111: begin is_cond = 1'b1; taken = ~ra_le_zero;       end
      6'b000010, 6'b000011: sel_next = 2'b10;
      6'b000000: if (funct == 6'b001000 || funct == 6'b001001) sel_next = 2'b11;
      default: ;
    endcase
    if (is_cond && taken) sel_next = 2'b01;
  end

  assign mp_next = is_cond & (taken != id_pred_taken);

  // Counter training: saturating step toward the resolved direction.
  assign ctr_cur  = bht_q[id_idx];
  always_comb begin
    ctr_next = ctr_cur;
    if (taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  assign bht_upd = (PREDICT_EN != 0) && fire && is_cond;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_bht
      logic [1:0] ctr_reg;
      always_ff @(posedge clk) begin
        if (!rst_n)
          ctr_reg <= 2'b01;
        else if (bht_upd && (id_idx == BHT_IDX'(gi)))
          ctr_reg <= ctr_next;
      end
      assign bht_q[gi] = ctr_reg;
    end
  endgenerate

  // Lookup reads the registered entry, so a same-cycle update is not visible yet.
  assign if_pred_taken = (PREDICT_EN != 0) ? bht_q[if_idx][1] : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_reg <= 1'b0;
      res_sel_reg   <= 2'b00;
      res_mp_reg    <= 1'b0;
      res_flush_reg <= 1'b0;
      perf_br_reg   <= '0;
      perf_mp_reg   <= '0;
    end else begin
      res_valid_reg <= fire;
      res_sel_reg   <= fire ? sel_next : 2'b00;
      res_mp_reg    <= fire & mp_next;
      res_flush_reg <= fire & (mp_next | sel_next[1]);
      if (fire && is_cond && !(&perf_br_reg))
        perf_br_reg <= perf_br_reg + CNT_W'(1);
      if (fire && mp_next && !(&perf_mp_reg))
        perf_mp_reg <= perf_mp_reg + CNT_W'(1);
    end
  end

  assign res_valid      = res_valid_reg;
  assign res_sel        = res_sel_reg;
  assign res_mispredict = res_mp_reg;
  assign res_flush      = res_flush_reg;
  assign perf_br_cnt    = perf_br_reg;
  assign perf_mp_cnt    = perf_mp_reg;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: a dynamic instance and a static (PREDICT_EN=0, 3-bit counter)
// instance share stimulus; both are checked against a table/arithmetic reference model.
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        id_valid, id_stall, id_pred_taken;
  logic [31:0] id_pc, id_inst, id_ra, id_rb;

  logic        pt_a, rv_a, mp_a, fl_a;
  logic [1:0]  rs_a;
  logic [15:0] br_a, mpc_a;
  logic        pt_b, rv_b, mp_b, fl_b;
  logic [1:0]  rs_b;
  logic [2:0]  br_b, mpc_b;

  int n_checks = 0;
  int n_fail   = 0;

  int tbl [64];
  int br_n, mp_n;
  int e_valid, e_sel, e_mp, e_flush;

  localparam logic [31:0] BEQ  = 32'h1000_0000;
  localparam logic [31:0] BNE  = 32'h1400_0000;
  localparam logic [31:0] BLEZ = 32'h1800_0000;
  localparam logic [31:0] BGTZ = 32'h1C00_0000;
  localparam logic [31:0] JMP  = 32'h0800_0000;
  localparam logic [31:0] JAL  = 32'h0C00_0000;
  localparam logic [31:0] JR   = 32'h0000_0008;
  localparam logic [31:0] JALR = 32'h0000_0009;
  localparam logic [31:0] ADD  = 32'h0000_0020;
  localparam logic [31:0] ADDI = 32'h2000_0000;

  always #5 clk = ~clk;

  branch_predict_resolve #(.DW(32), .BHT_IDX(6), .PREDICT_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(pt_a),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc), .id_inst(id_inst),
    .id_ra(id_ra), .id_rb(id_rb), .id_pred_taken(id_pred_taken),
    .res_valid(rv_a), .res_sel(rs_a), .res_mispredict(mp_a), .res_flush(fl_a),
    .perf_br_cnt(br_a), .perf_mp_cnt(mpc_a));

  branch_predict_resolve #(.DW(32), .BHT_IDX(6), .PREDICT_EN(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(pt_b),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc), .id_inst(id_inst),
    .id_ra(id_ra), .id_rb(id_rb), .id_pred_taken(id_pred_taken),
    .res_valid(rv_b), .res_sel(rs_b), .res_mispredict(mp_b), .res_flush(fl_b),
    .perf_br_cnt(br_b), .perf_mp_cnt(mpc_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Reference decode written from the instruction-set rules.
  task automatic classify(input logic [31:0] inst, input logic [31:0] ra, input logic [31:0] rb,
                          output bit cond, output bit tk, output int sel);
    int op, fn;
    op = int'(inst >> 26);
    fn = int'(inst & 32'h3F);
    cond = 0; tk = 0; sel = 0;
    case (op)
      4: begin cond = 1; tk = (ra == rb); end
      5: begin cond = 1; tk = (ra != rb); end
      6: begin cond = 1; tk = ($signed(ra) <= 0); end
      7: begin cond = 1; tk = ($signed(ra) > 0); end
      2, 3: sel = 2;
      0: if (fn == 8 || fn == 9) sel = 3;
      default: ;
    endcase
    if (cond && tk) sel = 1;
  endtask

  task automatic step(input bit rstn, input bit vld, input bit stl, input logic [31:0] pc,
                      input logic [31:0] inst, input logic [31:0] ra, input logic [31:0] rb,
                      input bit pred, input logic [31:0] fpc, input string tag);
    bit cond, tk, fire;
    int sel, idx;
    @(negedge clk);
    rst_n = rstn; id_valid = vld; id_stall = stl; id_pc = pc; id_inst = inst;
    id_ra = ra; id_rb = rb; id_pred_taken = pred; if_pc = fpc;
    #1;
    chk({tag, ".pred_a"}, {31'b0, pt_a}, (tbl[(fpc >> 2) % 64] >= 2) ? 32'd1 : 32'd0);
    chk({tag, ".pred_b"}, {31'b0, pt_b}, 32'd0);
    @(posedge clk);
    classify(inst, ra, rb, cond, tk, sel);
    fire = rstn && vld && !stl;
    if (!rstn) begin
      foreach (tbl[i]) tbl[i] = 1;
      br_n = 0; mp_n = 0;
      e_valid = 0; e_sel = 0; e_mp = 0; e_flush = 0;
    end else begin
      e_valid = fire;
      e_sel   = fire ? sel : 0;
      e_mp    = (fire && cond && (tk != pred)) ? 1 : 0;
      e_flush = (e_mp == 1 || e_sel >= 2) ? 1 : 0;
      if (fire && cond) begin
        br_n++;
        if (e_mp == 1) mp_n++;
        idx = (pc >> 2) % 64;
        tbl[idx] = tk ? ((tbl[idx] < 3) ? tbl[idx] + 1 : 3) : ((tbl[idx] > 0) ? tbl[idx] - 1 : 0);
      end
    end
    #1;
    $display("step %-10s rst_n=%0d fire=%0d pc=%h inst=%h ra=%h rb=%h pred=%0d -> sel=%0d mp=%0d flush=%0d",
             tag, rstn, fire, pc, inst, ra, rb, pred, rs_a, mp_a, fl_a);
    chk({tag, ".valid_a"}, {31'b0, rv_a}, e_valid);
    chk({tag, ".sel_a"},   {30'b0, rs_a}, e_sel);
    chk({tag, ".mp_a"},    {31'b0, mp_a}, e_mp);
    chk({tag, ".flush_a"}, {31'b0, fl_a}, e_flush);
    chk({tag, ".valid_b"}, {31'b0, rv_b}, e_valid);
    chk({tag, ".sel_b"},   {30'b0, rs_b}, e_sel);
    chk({tag, ".mp_b"},    {31'b0, mp_b}, e_mp);
    chk({tag, ".flush_b"}, {31'b0, fl_b}, e_flush);
    chk({tag, ".br_a"},    {16'b0, br_a},  sat(br_n, 65535));
    chk({tag, ".mpc_a"},   {16'b0, mpc_a}, sat(mp_n, 65535));
    chk({tag, ".br_b"},    {29'b0, br_b},  sat(br_n, 7));
    chk({tag, ".mpc_b"},   {29'b0, mpc_b}, sat(mp_n, 7));
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd5;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ops [10];
    logic [31:0] ra, rb, pc, fpc;
    ops = '{BEQ, BNE, BLEZ, BGTZ, JMP, JAL, JR, JALR, ADD, ADDI};
    foreach (tbl[i]) tbl[i] = 1;
    br_n = 0; mp_n = 0;
    rst_n = 1'b0; id_valid = 1'b0; id_stall = 1'b0; id_pc = '0; id_inst = '0;
    id_ra = '0; id_rb = '0; id_pred_taken = 1'b0; if_pc = '0;

    // Reset, including a fire presented during reset that must be discarded.
    step(0, 1, 0, 32'h40, BEQ, 5, 5, 0, 32'h40, "rst0");
    step(0, 1, 0, 32'h40, BEQ, 5, 5, 0, 32'h40, "rst1");
    // Train 0x40: 01 -> 10 -> 11 (saturate), then a not-taken back to 10.
    step(1, 1, 0, 32'h40, BEQ, 5, 5, 0, 32'h40, "beq_t0");
    step(1, 1, 0, 32'h40, BEQ, 5, 5, 1, 32'h40, "beq_t1");
    step(1, 1, 0, 32'h40, BEQ, 5, 5, 1, 32'h40, "beq_t2");
    step(1, 1, 0, 32'h40, BEQ, 5, 5, 1, 32'h40, "beq_t3");
    step(1, 1, 0, 32'h40, BEQ, 5, 6, 1, 32'h40, "beq_nt");
    step(1, 1, 0, 32'h44, JALR, 1, 2, 0, 32'h40, "jalr");
    step(1, 1, 0, 32'h48, BGTZ, 32'h8000_0000, 0, 1, 32'h48, "bgtz_neg");
    step(1, 1, 0, 32'h4C, BLEZ, 0, 0, 0, 32'h48, "blez_zero");
    step(1, 1, 1, 32'h40, BEQ, 5, 5, 0, 32'h40, "stall");
    step(1, 1, 0, 32'h50, BNE, 3, 4, 1, 32'h4C, "bne_t");
    step(1, 1, 0, 32'h54, JMP, 0, 0, 0, 32'h50, "j");
    step(1, 1, 0, 32'h58, JAL, 0, 0, 0, 32'h54, "jal");
    step(1, 1, 0, 32'h5C, JR, 0, 0, 1, 32'h58, "jr");
    step(1, 1, 0, 32'h60, ADD, 0, 0, 1, 32'h5C, "add");
    step(1, 0, 0, 32'h40, BEQ, 5, 5, 0, 32'h40, "idle");
    step(0, 1, 0, 32'h40, BEQ, 5, 5, 0, 32'h40, "rst_fire");
    // Four taken beqs at one PC: static instance never predicts taken.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h80, BEQ, 9, 9, 0, 32'h80, "static_t");
    step(1, 0, 0, 32'h0, ADD, 0, 0, 0, 32'h80, "idle2");

    // Randomised stream over a small PC set so entries train and counters saturate.
    for (int n = 0; n < 400; n++) begin
      ra  = pick_val();
      rb  = ($urandom_range(0, 2) == 0) ? ra : pick_val();
      pc  = 32'(($urandom_range(0, 7)) * 4 + 32'h100);
      fpc = ($urandom_range(0, 1) == 0) ? pc : 32'(($urandom_range(0, 7)) * 4 + 32'h100);
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0),
           pc, ops[$urandom_range(0, 9)], ra, rb, 1'($urandom_range(0, 1)), fpc, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

Interface
REQ-001 Parameter DW, default 32: operand width of ra/rb compare.
REQ-002 Parameter BHT_IDX, default 6: branch history table depth is 2^BHT_IDX entries of 2-bit counters, indexed by pc[BHT_IDX+1:2].
REQ-003 Parameter PREDICT_EN, default 1: 1 = dynamic prediction; 0 = static not-taken, table frozen at reset value.
REQ-004 Parameter CNT_W, default 16: width of performance counters.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 if_pc  input  32  fetch-stage PC for prediction lookup.
REQ-008 if_pred_taken  output  1  combinational: MSB of the table entry at if_pc index (0 when PREDICT_EN=0).
REQ-009 id_valid  input  1  decode-stage instruction valid.
REQ-010 id_stall  input  1  decode stage stalled; resolution suppressed.
REQ-011 id_pc  input  32  PC of decode instruction.
REQ-012 id_inst  input  32  decode instruction word.
REQ-013 id_ra, id_rb  input  DW each  forwarded rs/rt values.
REQ-014 id_pred_taken  input  1  prediction carried with the instruction from fetch.
REQ-015 res_valid  output  1  registered: a resolution result is present this cycle.
REQ-016 res_sel  output  2  registered next-PC select: 00 sequential, 01 PC+4+offset, 10 j/jal target, 11 register (jr/jalr).
REQ-017 res_mispredict  output  1  registered: conditional branch outcome differs from id_pred_taken.
REQ-018 res_flush  output  1  registered: fetch must be redirected/flushed.
REQ-019 perf_br_cnt, perf_mp_cnt  output  CNT_W each  resolved conditional branches / mispredicts.

Function
REQ-020 Resolution fires when id_valid=1 and id_stall=0 ("fire"); results appear on res_* exactly one cycle later.
REQ-021 Decode: opcode 000100 beq taken iff ra==rb; 000101 bne iff ra!=rb; 000110 blez iff signed ra<=0; 000111 bgtz iff signed ra>0; all compares at full DW.
REQ-022 Opcode 000010 j / 000011 jal -> res_sel=10; opcode 000000 with funct 001000 jr or 001001 jalr -> res_sel=11; all four unconditional.
REQ-023 Conditional taken -> res_sel=01; conditional not-taken or any other instruction -> res_sel=00.
REQ-024 res_mispredict=1 only for conditional branches with taken != id_pred_taken; 0 for all others.
REQ-025 res_flush = res_mispredict OR res_sel in {10,11}.
REQ-026 No fire in a cycle -> next cycle res_valid=0, res_sel=00, res_mispredict=0, res_flush=0.
REQ-027 On fire of a conditional branch with PREDICT_EN=1, entry at id_pc index updates: taken -> increment saturating at 11; not-taken -> decrement saturating at 00; other instructions never update.
REQ-028 Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction = MSB.
REQ-029 Same-cycle lookup and update of one index: if_pred_taken returns pre-update value (no bypass).
REQ-030 perf_br_cnt increments on each conditional fire; perf_mp_cnt on each conditional fire that mispredicts; both saturate at all-ones, no wrap.

Reset
REQ-031 rst_n=0 at a clock edge: all table entries -> 01, res_* -> 0, perf counters -> 0; fire in that cycle is discarded.
REQ-032 Reset mid-stream takes priority over any concurrent fire/update; outputs 0 the cycle after reset deasserts unless a fire occurred in the first cycle with rst_n=1.

Verification
REQ-033 After reset, if_pc=0x40 -> if_pred_taken=0; beq ra=rb=5 at id_pc 0x40, id_pred_taken=0 -> next cycle res_sel=01, mispredict=1, flush=1, entry 0x40 becomes 10.
REQ-034 Same beq repeated 3 times -> entry saturates at 11; one not-taken (ra=5, rb=6, pred=1) -> res_sel=00, mispredict=1, entry 10.
REQ-035 jalr (op 0, funct 001001) -> res_sel=11, flush=1, mispredict=0, table and perf counters unchanged.
REQ-036 bgtz ra=0x80000000 -> not taken (signed negative); blez ra=0 -> taken.
REQ-037 id_stall=1 with valid beq -> res_valid=0, no table or counter change; rst_n=0 with a fire in the same cycle -> all outputs 0, entry stays 01.
REQ-038 PREDICT_EN=0: 4 taken beq at same PC -> if_pred_taken stays 0, every one flags mispredict; perf_mp_cnt=4.
